// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-rate divider, raster counters and run/stop sequencer
// for the colour-bar generator. Every output is a flop loaded from the
// next-state counters, so sync/valid/coordinates always agree with each other.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        dValid,
  output logic [9:0]  xCor,
  output logic [9:0]  yCor,
  output logic        sof,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         hcnt_q, hcnt_d;
  logic [9:0]         vcnt_q, vcnt_d;
  logic [15:0]        frame_q, frame_d;
  logic               sof_q, sof_d;
  logic               busy_q, busy_d;
  logic               pix_q, pix_d;
  logic               dvalid_q, dvalid_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;

  logic               tick_s;
  logic               frame_end_s;
  logic [9:0]         hadv_s, vadv_s;

  // Pixel enable and end-of-frame detect, both from the current registered state
  assign tick_s      = (state_q != ST_IDLE) && (div_q == DIV_LAST);
  assign frame_end_s = tick_s && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  // Raster position after one pixel tick, wrapping at line and frame end
  always_comb begin
    hadv_s = hcnt_q;
    vadv_s = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hadv_s = 10'd0;
      if (vcnt_q == V_LAST) begin
        vadv_s = 10'd0;
      end else begin
        vadv_s = vcnt_q + 10'd1;
      end
    end else begin
      hadv_s = hcnt_q + 10'd1;
    end
  end

  // Next-state logic: run/stop FSM, divider, counters, frame bookkeeping
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    sof_d   = 1'b0;

    // divider only runs outside IDLE; it is back at 0 whenever IDLE is entered
    if (state_q == ST_IDLE) begin
      div_d = {DIV_W{1'b0}};
    end else if (div_q == DIV_LAST) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      ST_IDLE: begin
        hcnt_d = 10'd0;
        vcnt_d = 10'd0;
        if (en) begin
          state_d = ST_RUN;
          sof_d   = 1'b1;
          frame_d = frame_q + 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          hcnt_d = hadv_s;
          vcnt_d = vadv_s;
        end else begin
          hcnt_d = hcnt_q;
          vcnt_d = vcnt_q;
        end
        if (frame_end_s) begin
          sof_d   = 1'b1;
          frame_d = frame_q + 16'd1;
        end else begin
          sof_d   = 1'b0;
        end
        state_d = en ? ST_RUN : ST_FINISH;
      end
      ST_FINISH: begin
        if (tick_s) begin
          hcnt_d = hadv_s;
          vcnt_d = vadv_s;
        end else begin
          hcnt_d = hcnt_q;
          vcnt_d = vcnt_q;
        end
        if (frame_end_s && !en) begin
          // wrapped counters are already (0,0); stop without a new frame
          state_d = ST_IDLE;
        end else if (frame_end_s) begin
          state_d = ST_RUN;
          sof_d   = 1'b1;
          frame_d = frame_q + 16'd1;
        end else begin
          state_d = en ? ST_RUN : ST_FINISH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = {DIV_W{1'b0}};
        hcnt_d  = 10'd0;
        vcnt_d  = 10'd0;
      end
    endcase
  end

  // Output decode from next-state values so the output flops line up with the counters
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    pix_d    = busy_d && (div_d == DIV_LAST);
    dvalid_d = busy_d && (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    if (busy_d && (hcnt_d >= HS_START) && (hcnt_d < HS_END)) begin
      hsync_d = SYNC_POL;
    end else begin
      hsync_d = ~SYNC_POL;
    end
    if (busy_d && (vcnt_d >= VS_START) && (vcnt_d < VS_END)) begin
      vsync_d = SYNC_POL;
    end else begin
      vsync_d = ~SYNC_POL;
    end
  end

  // State, divider and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= {DIV_W{1'b0}};
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      frame_q <= 16'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
    end
  end

  // Registered outputs, inactive levels in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_q    <= 1'b0;
      busy_q   <= 1'b0;
      pix_q    <= 1'b0;
      dvalid_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      sof_q    <= sof_d;
      busy_q   <= busy_d;
      pix_q    <= pix_d;
      dvalid_q <= dvalid_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign pix_tick  = pix_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign dValid    = dvalid_q;
  assign xCor      = hcnt_q;
  assign yCor      = vcnt_q;
  assign sof       = sof_q;
  assign frame_cnt = frame_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster: 15 pixels x 10 lines
// (active 8x6, hsync at h 10..12, vsync at v 7..8). Instance A uses
// CLK_DIV=2 (300 clks/frame), instance B uses CLK_DIV=1 (150 clks/frame).
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_b;
  logic pix_a, hs_a, vs_a, dv_a, sof_a, busy_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;
  logic pix_b, hs_b, vs_b, dv_b, sof_b, busy_b;
  logic [9:0] x_b, y_b;
  logic [15:0] fc_b;

  vga_timing_ctrl #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .pix_tick(pix_a), .hsync(hs_a),
    .vsync(vs_a), .dValid(dv_a), .xCor(x_a), .yCor(y_a), .sof(sof_a),
    .frame_cnt(fc_a), .busy(busy_a)
  );

  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .pix_tick(pix_b), .hsync(hs_b),
    .vsync(vs_b), .dValid(dv_b), .xCor(x_b), .yCor(y_b), .sof(sof_b),
    .frame_cnt(fc_b), .busy(busy_b)
  );

  typedef struct {
    int n;      // clock edge index (edge 0 = first edge after reset release)
    int en;     // en level held while advancing to edge n
    int busy;
    int pix;
    int x;
    int y;
    int dv;
    int hs;
    int vs;
    int sof;
    int fc;
  } vec_t;

  vec_t tbl[40];
  int   nv = 0;
  int   cur;
  int   checks = 0;
  int   failures = 0;
  int   sof_seen_a = 0;

  // Count every sof pulse seen on instance A
  always @(negedge clk) begin
    if (sof_a === 1'b1) sof_seen_a++;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic add(input int n, input int en, input int b, input int p, input int x, input int y,
                     input int dv, input int hs, input int vs, input int s, input int fc);
    tbl[nv] = '{n, en, b, p, x, y, dv, hs, vs, s, fc};
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cur++;
  endtask

  task automatic chk_a_idle(input int idx, input int fc);
    chk("idle_busy", idx, {31'd0, busy_a}, 32'd0);
    chk("idle_pix", idx, {31'd0, pix_a}, 32'd0);
    chk("idle_x", idx, {22'd0, x_a}, 32'd0);
    chk("idle_y", idx, {22'd0, y_a}, 32'd0);
    chk("idle_dv", idx, {31'd0, dv_a}, 32'd0);
    chk("idle_hs", idx, {31'd0, hs_a}, 32'd1);
    chk("idle_vs", idx, {31'd0, vs_a}, 32'd1);
    chk("idle_sof", idx, {31'd0, sof_a}, 32'd0);
    chk("idle_fc", idx, {16'd0, fc_a}, fc);
  endtask

  initial begin
    int k, pix_low, hs_low, vs_low, dv_hi;

    //   n     en busy pix  x   y  dv hs vs sof fc
    add(   0, 1, 1, 0,  0, 0, 1, 1, 1, 1, 1);
    add(   1, 1, 1, 1,  0, 0, 1, 1, 1, 0, 1);
    add(  14, 1, 1, 0,  7, 0, 1, 1, 1, 0, 1);
    add(  16, 1, 1, 0,  8, 0, 0, 1, 1, 0, 1);
    add(  19, 1, 1, 1,  9, 0, 0, 1, 1, 0, 1);
    add(  20, 1, 1, 0, 10, 0, 0, 0, 1, 0, 1);
    add(  25, 1, 1, 1, 12, 0, 0, 0, 1, 0, 1);
    add(  26, 1, 1, 0, 13, 0, 0, 1, 1, 0, 1);
    add(  29, 1, 1, 1, 14, 0, 0, 1, 1, 0, 1);
    add(  30, 1, 1, 0,  0, 1, 1, 1, 1, 0, 1);
    add( 180, 1, 1, 0,  0, 6, 0, 1, 1, 0, 1);
    add( 209, 1, 1, 1, 14, 6, 0, 1, 1, 0, 1);
    add( 210, 1, 1, 0,  0, 7, 0, 1, 0, 0, 1);
    add( 240, 1, 1, 0,  0, 8, 0, 1, 0, 0, 1);
    add( 270, 1, 1, 0,  0, 9, 0, 1, 1, 0, 1);
    add( 299, 1, 1, 1, 14, 9, 0, 1, 1, 0, 1);
    add( 300, 1, 1, 0,  0, 0, 1, 1, 1, 1, 2);
    add( 301, 1, 1, 1,  0, 0, 1, 1, 1, 0, 2);
    add( 600, 1, 1, 0,  0, 0, 1, 1, 1, 1, 3);
    // drop en mid-frame: raster completes, then idle
    add( 650, 1, 1, 0, 10, 1, 0, 0, 1, 0, 3);
    add( 651, 0, 1, 1, 10, 1, 0, 0, 1, 0, 3);
    add( 899, 0, 1, 1, 14, 9, 0, 1, 1, 0, 3);
    add( 900, 0, 0, 0,  0, 0, 0, 1, 1, 0, 3);
    add( 910, 0, 0, 0,  0, 0, 0, 1, 1, 0, 3);
    // restart, drop, reassert before frame end: seamless continuation
    add( 911, 1, 1, 0,  0, 0, 1, 1, 1, 1, 4);
    add(1000, 1, 1, 1, 14, 2, 0, 1, 1, 0, 4);
    add(1001, 0, 1, 0,  0, 3, 1, 1, 1, 0, 4);
    add(1100, 0, 1, 1,  4, 6, 0, 1, 1, 0, 4);
    add(1101, 1, 1, 0,  5, 6, 0, 1, 1, 0, 4);
    add(1210, 1, 1, 1, 14, 9, 0, 1, 1, 0, 4);
    add(1211, 1, 1, 0,  0, 0, 1, 1, 1, 1, 5);
    // en drops exactly on the final tick in RUN: wrap, then one more frame
    add(1510, 1, 1, 1, 14, 9, 0, 1, 1, 0, 5);
    add(1511, 0, 1, 0,  0, 0, 1, 1, 1, 1, 6);
    add(1810, 0, 1, 1, 14, 9, 0, 1, 1, 0, 6);
    add(1811, 0, 0, 0,  0, 0, 0, 1, 1, 0, 6);
    // en returns in FINISH exactly on the final tick: RUN wins
    add(1812, 1, 1, 0,  0, 0, 1, 1, 1, 1, 7);
    add(1813, 0, 1, 1,  0, 0, 1, 1, 1, 0, 7);
    add(2111, 0, 1, 1, 14, 9, 0, 1, 1, 0, 7);
    add(2112, 1, 1, 0,  0, 0, 1, 1, 1, 1, 8);
    add(2113, 1, 1, 1,  0, 0, 1, 1, 1, 0, 8);

    // reset state
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);
    chk_a_idle(-1, 0);
    rst_n = 1'b1;
    cur = -1;

    // table-driven raster and FSM checks on instance A
    for (int i = 0; i < nv; i++) begin
      en_a = tbl[i].en[0];
      while (cur < tbl[i].n) step();
      chk("busy", i, {31'd0, busy_a}, tbl[i].busy);
      chk("pix_tick", i, {31'd0, pix_a}, tbl[i].pix);
      chk("xCor", i, {22'd0, x_a}, tbl[i].x);
      chk("yCor", i, {22'd0, y_a}, tbl[i].y);
      chk("dValid", i, {31'd0, dv_a}, tbl[i].dv);
      chk("hsync", i, {31'd0, hs_a}, tbl[i].hs);
      chk("vsync", i, {31'd0, vs_a}, tbl[i].vs);
      chk("sof", i, {31'd0, sof_a}, tbl[i].sof);
      chk("frame_cnt", i, {16'd0, fc_a}, tbl[i].fc);
    end
    chk("sof_total_a", 0, sof_seen_a, 32'd8);
    chk("b_idle", 0, {31'd0, busy_b}, 32'd0);

    // CLK_DIV=1: full frame is 150 clks with pix_tick always high
    en_b = 1'b1;
    step();
    chk("b_first_sof", 0, {31'd0, sof_b}, 32'd1);
    chk("b_first_fc", 0, {16'd0, fc_b}, 32'd1);
    chk("b_first_x", 0, {22'd0, x_b}, 32'd0);
    chk("b_first_y", 0, {22'd0, y_b}, 32'd0);
    k = 0; pix_low = 0; hs_low = 0; vs_low = 0; dv_hi = 0;
    do begin
      if (pix_b !== 1'b1) pix_low++;
      if (hs_b === 1'b0) hs_low++;
      if (vs_b === 1'b0) vs_low++;
      if (dv_b === 1'b1) dv_hi++;
      k++;
      step();
    end while (sof_b !== 1'b1 && k < 1000);
    chk("b_frame_clks", 0, k, 32'd150);
    chk("b_pix_low", 0, pix_low, 32'd0);
    chk("b_hsync_low", 0, hs_low, 32'd30);
    chk("b_vsync_low", 0, vs_low, 32'd30);
    chk("b_dvalid_hi", 0, dv_hi, 32'd48);
    chk("b_second_fc", 0, {16'd0, fc_b}, 32'd2);
    en_b = 1'b0;

    // asynchronous reset mid-frame, between clock edges
    repeat (37) step();
    chk("pre_rst_busy", 0, {31'd0, busy_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_a_idle(99, 0);
    chk("rst_b_busy", 0, {31'd0, busy_b}, 32'd0);
    chk("rst_b_fc", 0, {16'd0, fc_b}, 32'd0);
    @(negedge clk);
    en_a  = 1'b1;
    rst_n = 1'b1;
    step();
    chk("post_rst_sof", 0, {31'd0, sof_a}, 32'd1);
    chk("post_rst_fc", 0, {16'd0, fc_a}, 32'd1);
    chk("post_rst_busy", 0, {31'd0, busy_a}, 32'd1);
    chk("post_rst_x", 0, {22'd0, x_a}, 32'd0);
    step();
    chk("post_rst_sof2", 0, {31'd0, sof_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
